// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the byte-serial memory arbiter: controller state
//   encoding, requester identity, load/store size encodings, the I/O space
//   decode value and a helper turning a size code into a byte count.

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Upper two RAM address bits equal to this value select I/O space.
    localparam logic [1:0] IO_SPACE = 2'b11;

    localparam logic [2:0] FETCH_BYTES = 3'd4;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide memory port between the instruction fetch unit and
//   the load/store unit. Each granted request is serialised into 1, 2 or 4
//   little-endian byte accesses; reads return one cycle after their address.
//   Writes into I/O space are throttled by io_buffer_full and a minimum gap.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   rdy_in                  global enable; low freezes the controller
//   mem_din                 read byte (one cycle after its address)
//   mem_dout, mem_a, mem_wr byte write data, byte address, write strobe
//   io_buffer_full          I/O output buffer cannot accept a byte
//   if_req, if_addr         fetch request (level) and word address
//   if_done, if_data        fetch completion pulse and fetched word
//   ls_req, ls_wr, ls_addr, ls_size, ls_wdata
//                           load/store request, direction, address, size, data
//   ls_done, ls_rdata       load/store completion pulse, zero-extended load data
//   flush_in                abort an in-progress fetch
//
// States
//   ST_IDLE  | no transaction; arbitrate between unmasked requests
//   ST_READ  | issuing byte addresses and capturing returned bytes
//   ST_WRITE | issuing write bytes, throttled for I/O space

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_GAP         = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic        flush_in
);

    localparam int GAP_W = (IO_GAP > 1) ? $clog2(IO_GAP + 1) : 1;

    arb_state_e        state;
    arb_state_e        state_next;
    owner_e            owner;
    owner_e            last_grant;
    logic [2:0]        idx;
    logic [2:0]        nbytes;
    logic              pend;
    logic [31:0]       base;
    logic [31:0]       wdata;
    logic [31:0]       rbuf;
    logic [31:0]       rbuf_next;
    logic [31:0]       wshift;
    logic [31:0]       byte_addr;
    logic [GAP_W-1:0]  gap_cnt;
    logic              if_done_q;
    logic              ls_done_q;

    logic if_live;
    logic ls_live;
    logic grant_if;
    logic grant_ls;
    logic is_io;
    logic io_ok;
    logic start_if;
    logic start_ls;
    logic rd_issue;
    logic rd_capture;
    logic wr_issue;
    logic finish;
    logic abort;

    // Done pulses are held back while the port is stalled.
    assign if_done = if_done_q & rdy_in;
    assign ls_done = ls_done_q & rdy_in;

    // A requester is ignored in the cycle its done pulse is showing, so a
    // level request that has just completed cannot be granted twice.
    assign if_live  = if_req & ~if_done;
    assign ls_live  = ls_req & ~ls_done;
    assign grant_if = if_live & (~ls_live | (last_grant == OWN_LS));
    assign grant_ls = ls_live & ~grant_if;

    assign is_io = (base[RAM_ADDR_WIDTH -: 2] == IO_SPACE);
    assign io_ok = ~is_io | (~io_buffer_full & (gap_cnt == '0));

    assign byte_addr = base + {29'd0, idx};
    assign wshift    = wdata >> {idx[1:0], 3'd0};
    // pend guarantees idx >= 1, so idx-1 is the byte that is arriving now.
    assign rbuf_next = rbuf | ({24'd0, mem_din} << {idx - 3'd1, 3'd0});

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_a      = '0;
        mem_dout   = '0;
        mem_wr     = 1'b0;
        start_if   = 1'b0;
        start_ls   = 1'b0;
        rd_issue   = 1'b0;
        rd_capture = 1'b0;
        wr_issue   = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (grant_if) begin
                        start_if   = 1'b1;
                        state_next = ST_READ;
                    end else if (grant_ls) begin
                        start_ls   = 1'b1;
                        state_next = ls_wr ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if ((owner == OWN_IF) && flush_in) begin
                        abort      = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        rd_capture = pend;
                        if (idx < nbytes) begin
                            rd_issue = 1'b1;
                            mem_a    = byte_addr;
                        end else begin
                            finish     = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (io_ok) begin
                        wr_issue = 1'b1;
                        mem_wr   = 1'b1;
                        mem_a    = byte_addr;
                        mem_dout = wshift[7:0];
                        if (idx == nbytes - 3'd1) begin
                            finish     = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if ((state == ST_READ) && pend) begin
            // Keep the in-flight byte addressed through the stall so its data
            // is present on mem_din when rdy_in returns.
            mem_a = byte_addr - 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            owner      <= OWN_IF;
            last_grant <= OWN_LS;
            idx        <= '0;
            nbytes     <= '0;
            pend       <= 1'b0;
            base       <= '0;
            wdata      <= '0;
            rbuf       <= '0;
            gap_cnt    <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data    <= '0;
            ls_rdata   <= '0;
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            if (start_if) begin
                owner      <= OWN_IF;
                last_grant <= OWN_IF;
                base       <= if_addr;
                nbytes     <= FETCH_BYTES;
                wdata      <= '0;
            end
            if (start_ls) begin
                owner      <= OWN_LS;
                last_grant <= OWN_LS;
                base       <= ls_addr;
                nbytes     <= size_bytes(ls_size);
                wdata      <= ls_wdata;
            end
            if (start_if || start_ls) begin
                idx  <= '0;
                pend <= 1'b0;
                rbuf <= '0;
            end
            if (rd_capture) begin
                rbuf <= rbuf_next;
            end
            if (rd_issue) begin
                idx  <= idx + 3'd1;
                pend <= 1'b1;
            end
            if (wr_issue) begin
                idx <= idx + 3'd1;
                if (is_io) begin
                    gap_cnt <= GAP_W'(IO_GAP);
                end
            end
            if (finish) begin
                pend <= 1'b0;
                if (owner == OWN_IF) begin
                    if_done_q <= 1'b1;
                    if_data   <= rbuf_next;
                end else begin
                    ls_done_q <= 1'b1;
                    if (state == ST_READ) begin
                        ls_rdata <= rbuf_next;
                    end
                end
            end
            if (abort) begin
                pend <= 1'b0;
                rbuf <= '0;
            end
        end
    end

endmodule
